// File: rtl/spi_slave.sv
// SPI slave: 2-flop synchronized sclk/cs/mosi, mode 0/1 phase select,
// single TX holding register and back-to-back frame support.
module spi_slave #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs,
   input  logic              mosi,
   input  logic              mode,
   output logic              miso,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy
);

   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   logic [0:0]        state;
   logic              mode_r;
   logic [CW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shift_tx;
   logic [DATA_W-1:0] shift_rx;
   logic [DATA_W-1:0] hold;
   logic              cs_s1, cs_s2, cs_prev;
   logic              sclk_s1, sclk_s2, sclk_prev;
   logic              mosi_s1, mosi_s2;

   logic              cs_fall, cs_rise;
   logic              sclk_rise, sclk_fall;
   logic              sample_edge, shift_edge;
   logic              last_bit, reload, load_ok;
   logic [DATA_W-1:0] tx_next;
   logic [DATA_W-1:0] rx_next;

   assign cs_fall     = cs_prev & ~cs_s2;
   assign cs_rise     = ~cs_prev & cs_s2;
   assign sclk_rise   = ~sclk_prev & sclk_s2;
   assign sclk_fall   = sclk_prev & ~sclk_s2;
   assign sample_edge = mode_r ? sclk_fall : sclk_rise;
   assign shift_edge  = mode_r ? sclk_rise : sclk_fall;
   assign last_bit    = bit_cnt == CW'(DATA_W - 1);
   assign reload      = (state == IDLE && cs_fall) ||
                        (state == XFER && !cs_rise &&
                         sample_edge && last_bit);
   assign load_ok     = tx_load && (tx_ready || reload);
   assign tx_next     = tx_ready ? '0 : hold;
   assign rx_next     = {shift_rx[DATA_W-2:0], mosi_s2};
   assign busy        = state == XFER;

   // Two-flop synchronizers plus previous-value flops for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_s1     <= 1'b1;
         cs_s2     <= 1'b1;
         cs_prev   <= 1'b1;
         sclk_s1   <= 1'b0;
         sclk_s2   <= 1'b0;
         sclk_prev <= 1'b0;
         mosi_s1   <= 1'b0;
         mosi_s2   <= 1'b0;
      end else begin
         cs_s1     <= cs;
         cs_s2     <= cs_s1;
         cs_prev   <= cs_s2;
         sclk_s1   <= sclk;
         sclk_s2   <= sclk_s1;
         sclk_prev <= sclk_s2;
         mosi_s1   <= mosi;
         mosi_s2   <= mosi_s1;
      end
   end

   // TX holding register: a reload empties it before a same-cycle capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold     <= '0;
         tx_ready <= 1'b1;
      end else if (load_ok) begin
         hold     <= tx_data;
         tx_ready <= 1'b0;
      end else if (reload) begin
         tx_ready <= 1'b1;
      end
   end

   // Frame FSM: bit counting, shift registers, miso and rx hand-off
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         mode_r   <= 1'b0;
         bit_cnt  <= '0;
         shift_tx <= '0;
         shift_rx <= '0;
         miso     <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               miso <= 1'b0;
               if (cs_fall) begin
                  state   <= XFER;
                  mode_r  <= mode;
                  bit_cnt <= '0;
                  if (!mode) begin
                     miso     <= tx_next[DATA_W-1];
                     shift_tx <= tx_next << 1;
                  end else begin
                     shift_tx <= tx_next;
                  end
               end
            end
            default: begin
               if (cs_rise) begin
                  state   <= IDLE;
                  bit_cnt <= '0;
                  miso    <= 1'b0;
               end else if (sample_edge) begin
                  shift_rx <= rx_next;
                  if (last_bit) begin
                     rx_data  <= rx_next;
                     rx_valid <= 1'b1;
                     bit_cnt  <= '0;
                     if (!mode_r) begin
                        miso     <= tx_next[DATA_W-1];
                        shift_tx <= tx_next << 1;
                     end else begin
                        shift_tx <= tx_next;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (shift_edge && (mode_r || bit_cnt != '0)) begin
                  miso     <= shift_tx[DATA_W-1];
                  shift_tx <= shift_tx << 1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed SPI frames, rx scoreboard
// popped by an independent rx_valid monitor.
module tb_spi_slave;

   localparam int H = 80;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0;
   logic       cs = 1'b1;
   logic       mosi = 1'b0;
   logic       mode = 1'b0;
   logic       miso;
   logic [7:0] tx_data = '0;
   logic       tx_load = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;

   int passed = 0;
   int total = 0;
   logic [7:0] exp_q[$];
   logic       prev_valid = 1'b0;
   logic [7:0] got, got2;

   spi_slave #(.DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs),
      .mosi(mosi), .mode(mode), .miso(miso),
      .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every rx_valid pulse is matched against the scoreboard
   always @(negedge clk) begin
      if (rx_valid) begin
         chk("rx_valid_width", int'(prev_valid), 0);
         if (exp_q.size() == 0) begin
            chk("rx_unexpected", 1, 0);
         end else begin
            chk("rx_data", int'(rx_data), int'(exp_q.pop_front()));
         end
      end
      prev_valid = rx_valid;
   end

   task automatic load(input logic [7:0] d);
      @(negedge clk);
      tx_data = d;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
   endtask

   task automatic frame(input logic m, input logic [7:0] d,
                        input bit do_start, input bit do_end,
                        input int nbits, output logic [7:0] rcv);
      rcv = '0;
      mode = m;
      if (do_start) begin
         cs = 1'b0;
         if (m) #H;
      end
      for (int i = 0; i < nbits; i++) begin
         if (!m) begin
            mosi = d[7-i];
            #H;
            sclk = 1'b1;
            rcv = {rcv[6:0], miso};
            #H;
            sclk = 1'b0;
         end else begin
            sclk = 1'b1;
            mosi = d[7-i];
            #H;
            sclk = 1'b0;
            rcv = {rcv[6:0], miso};
            #H;
         end
      end
      if (do_end) begin
         #H;
         cs = 1'b1;
         #(2 * H);
      end
   endtask

   initial begin
      #23;
      @(negedge clk);
      chk("reset_miso", int'(miso), 0);
      chk("reset_rx_data", int'(rx_data), 0);
      chk("reset_rx_valid", int'(rx_valid), 0);
      chk("reset_tx_ready", int'(tx_ready), 1);
      chk("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // mode 0: tx 0x5A, rx 0xB3
      load(8'h5A);
      chk("tx_ready_after_load", int'(tx_ready), 0);
      exp_q.push_back(8'hB3);
      frame(1'b0, 8'hB3, 1, 1, 8, got);
      chk("m0_miso_bits", int'(got), 'h5A);
      chk("tx_ready_after_frame", int'(tx_ready), 1);
      chk("busy_idle", int'(busy), 0);

      // mode 1: tx 0xC3, rx 0x3C
      load(8'hC3);
      exp_q.push_back(8'h3C);
      frame(1'b1, 8'h3C, 1, 1, 8, got);
      chk("m1_miso", int'(got), 'hC3);

      // no tx loaded: miso stays low
      exp_q.push_back(8'hFF);
      frame(1'b0, 8'hFF, 1, 1, 8, got);
      chk("empty_tx_miso", int'(got), 0);

      // back-to-back frames, tx reloaded mid-frame-1
      load(8'hA1);
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
      fork
         frame(1'b0, 8'h12, 1, 0, 8, got);
         begin
            #(4 * H);
            chk("busy_xfer", int'(busy), 1);
            load(8'h7E);
         end
      join
      frame(1'b0, 8'h34, 0, 1, 8, got2);
      chk("b2b_miso1", int'(got), 'hA1);
      chk("b2b_miso2", int'(got2), 'h7E);

      // partial frame of 5 bits is discarded
      frame(1'b0, 8'hFF, 1, 1, 5, got);
      chk("partial_rx_kept", int'(rx_data), 'h34);
      load(8'h69);
      exp_q.push_back(8'h96);
      frame(1'b0, 8'h96, 1, 1, 8, got);
      chk("after_partial_miso", int'(got), 'h69);

      // reset mid-frame
      load(8'hF0);
      frame(1'b0, 8'hAA, 1, 0, 3, got);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_miso", int'(miso), 0);
      chk("midrst_rx_data", int'(rx_data), 0);
      chk("midrst_rx_valid", int'(rx_valid), 0);
      chk("midrst_tx_ready", int'(tx_ready), 1);
      chk("midrst_busy", int'(busy), 0);
      cs = 1'b1;
      sclk = 1'b0;
      #36;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // recovery after reset
      load(8'h3C);
      exp_q.push_back(8'h5C);
      frame(1'b1, 8'h5C, 1, 1, 8, got);
      chk("post_rst_miso", int'(got), 'h3C);

      repeat (10) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
